// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: bus-written byte FIFO drained by an 8N1 serial transmitter
//   clk, rst      clock and synchronous active-high reset
//   EN, P_Data    bus write strobe and data; P_Data[31]=1 clears ovf, else P_Data[7:0] is pushed
//   status        {ovf, busy, full, empty, 23'b0, count[4:0]}
//   tx            serial line, idle high
//   busy          a frame is in progress
//   tx_done       high during the last stop-bit clock when no further byte is queued
module uart_tx_fifo #(
   parameter int BAUD_DIV = 868,
   parameter int FIFO_AW = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        EN,
   input  logic [31:0] P_Data,
   output logic [31:0] status,
   output logic        tx,
   output logic        busy,
   output logic        tx_done
);
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int CW = FIFO_AW + 1;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state, state_n;
   logic [7:0] mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [15:0] timer;
   logic [2:0] bit_idx;
   logic [7:0] shift;
   logic [31:0] count_ext;
   logic ovf, empty, full, bit_end, pop, push, cmd, wr;
   assign empty = count == '0;
   assign full = count == CW'(DEPTH);
   assign bit_end = timer == 16'(BAUD_DIV - 1);
   // a pop at the end of STOP lets the next frame start with no idle gap
   assign pop = !empty && (state == IDLE || (state == STOP && bit_end));
   assign cmd = EN && P_Data[31];
   assign wr = EN && !P_Data[31];
   // a full FIFO still accepts a byte on the cycle the serializer frees a slot
   assign push = wr && (!full || pop);
   assign count_ext = 32'(count);
   assign busy = state != IDLE;
   assign tx = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
   assign tx_done = state == STOP && bit_end && empty;
   assign status = {ovf, busy, full, empty, 23'b0, count_ext[4:0]};
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = empty ? IDLE : START;
         START:   state_n = bit_end ? DATA : START;
         DATA:    state_n = (bit_end && bit_idx == 3'd7) ? STOP : DATA;
         STOP:    state_n = !bit_end ? STOP : empty ? IDLE : START;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         ovf <= 1'b0;
         timer <= '0;
         bit_idx <= '0;
         shift <= '0;
      end else begin
         state <= state_n;
         timer <= (state == IDLE || bit_end) ? '0 : timer + 16'd1;
         if (state == DATA && bit_end) begin
            shift <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
         end
         if (pop) begin
            shift <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
            bit_idx <= '0;
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
         if (cmd) ovf <= 1'b0;
         else if (wr && !push) ovf <= 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= P_Data[7:0];
   end
endmodule
